// File: rtl/otter_io_pkg.sv
// Shared definitions for the OTTER MCU I/O blocks.
// Holds the UART IOBUS address map and the UART transmit drain-engine
// state type. Imported by the UART transmit buffer and its sub-modules.
package otter_io_pkg;

    // IOBUS addresses decoded by the wrapper around the UART transmit buffer.
    localparam logic [31:0] UART_DATA_ADDR   = 32'h1100_0040;
    localparam logic [31:0] UART_STATUS_ADDR = 32'h1100_0044;

    // Drain engine states: wait for a byte, pulse start, wait for the UART
    // to take the byte (READY low), wait for the UART to finish (READY high).
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } uart_tx_state_t;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Bundle of the IOBUS write side, the UART handshake side and the status
// outputs of the UART transmit buffer.
//   slave  : seen by the buffer (takes writes/READY, drives START/DATA/status)
//   master : seen by whoever drives the buffer (IOBUS decode + UART model)
interface uart_tx_fifo_if #(
    parameter int DEPTH = 16,
    parameter int DW    = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          WR_EN;
    logic [DW-1:0] WR_DATA;
    logic          CLR_OVF;
    logic          TX_READY;
    logic          TX_START;
    logic [DW-1:0] TX_DATA;
    logic [CW-1:0] COUNT;
    logic          FULL;
    logic          EMPTY;
    logic          OVERFLOW;
    logic          BUSY;

    modport slave (
        input  WR_EN, WR_DATA, CLR_OVF, TX_READY,
        output TX_START, TX_DATA, COUNT, FULL, EMPTY, OVERFLOW, BUSY
    );

    modport master (
        output WR_EN, WR_DATA, CLR_OVF, TX_READY,
        input  TX_START, TX_DATA, COUNT, FULL, EMPTY, OVERFLOW, BUSY
    );
endinterface

// File: rtl/uart_tx_fifo_sync_fifo.sv
// sync_fifo: generic DEPTH x DW single-clock FIFO.
// Ports:
//   CLK, RST_N  clock and asynchronous active-low reset
//   push/push_data  enqueue request; accepted when not full, or when a pop
//                   happens in the same cycle and frees an entry
//   pop/pop_data    dequeue request (ignored when empty); pop_data shows the
//                   head entry combinationally
//   count/full/empty  registered occupancy status
// Occupancy is kept in its own counter rather than derived from the pointers.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int DW    = 8
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   push,
    input  logic [DW-1:0]          push_data,
    input  logic                   pop,
    output logic [DW-1:0]          pop_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_next_s;
    logic          full_r;
    logic          empty_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    // Accept/reject decisions and the next occupancy value.
    always_comb begin
        pop_ok_s     = pop && !empty_r;
        push_ok_s    = push && (!full_r || pop_ok_s);
        count_next_s = count_r;
        if (push_ok_s && !pop_ok_s) begin
            count_next_s = count_r + CW'(1);
        end else if (pop_ok_s && !push_ok_s) begin
            count_next_s = count_r - CW'(1);
        end else begin
            count_next_s = count_r;
        end
    end

    // Pointers and status registers; power-of-two depth makes pointer
    // increment wrap naturally.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r <= count_next_s;
            full_r  <= (count_next_s == CW'(DEPTH));
            empty_r <= (count_next_s == CW'(0));
        end
    end

    // Storage array; contents are don't-care after reset.
    always_ff @(posedge CLK) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    assign pop_data = mem_r[rd_ptr_r];
    assign count    = count_r;
    assign full     = full_r;
    assign empty    = empty_r;

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte buffer between the IOBUS UART data port and the UART
// transmitter.
// Ports:
//   CLK, RST_N  single system clock, asynchronous active-low reset
//   bus (slave) WR_EN/WR_DATA writes, CLR_OVF, TX_READY from the UART;
//               TX_START/TX_DATA to the UART; COUNT/FULL/EMPTY/OVERFLOW/BUSY
//               status for the IOBUS read mux.
// A drain engine pops one byte when the UART is ready, pulses TX_START for a
// single cycle, then waits for READY to fall (byte taken) and rise again
// (byte finished). If READY never falls the byte is treated as consumed after
// ACK_TIMEOUT cycles so a UART that skips the handshake cannot stall the queue.
module uart_tx_fifo
    import otter_io_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int DW          = 8,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic           CLK,
    input  logic           RST_N,
    uart_tx_fifo_if.slave  bus
);
    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    uart_tx_state_t        state_r;
    uart_tx_state_t        state_next_s;
    logic [TW-1:0]         tmo_r;
    logic [TW-1:0]         tmo_next_s;
    logic [DW-1:0]         tx_data_r;
    logic                  tx_start_r;
    logic                  ovf_r;
    logic                  ovf_next_s;
    logic                  pop_s;
    logic [DW-1:0]         fifo_head_s;
    logic [$clog2(DEPTH):0] fifo_count_s;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;

    sync_fifo #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_fifo (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .push      (bus.WR_EN),
        .push_data (bus.WR_DATA),
        .pop       (pop_s),
        .pop_data  (fifo_head_s),
        .count     (fifo_count_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    // Drain engine next-state, pop request and timeout counter.
    always_comb begin
        state_next_s = state_r;
        tmo_next_s   = tmo_r;
        pop_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (!fifo_empty_s && bus.TX_READY) begin
                    pop_s        = 1'b1;
                    state_next_s = ISSUE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ISSUE: begin
                tmo_next_s   = '0;
                state_next_s = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (!bus.TX_READY) begin
                    state_next_s = WAIT_DONE;
                end else if (tmo_r == TW'(ACK_TIMEOUT - 1)) begin
                    state_next_s = IDLE;
                end else begin
                    tmo_next_s = tmo_r + TW'(1);
                end
            end
            WAIT_DONE: begin
                if (bus.TX_READY) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = WAIT_DONE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Sticky overflow: a write into a full queue that no same-cycle pop
    // relieves; setting takes priority over a simultaneous clear.
    always_comb begin
        if (bus.WR_EN && fifo_full_s && !pop_s) begin
            ovf_next_s = 1'b1;
        end else if (bus.CLR_OVF) begin
            ovf_next_s = 1'b0;
        end else begin
            ovf_next_s = ovf_r;
        end
    end

    // Engine state, start pulse, presented byte and overflow flag.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r    <= IDLE;
            tmo_r      <= '0;
            tx_start_r <= 1'b0;
            tx_data_r  <= '0;
            ovf_r      <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            tmo_r      <= tmo_next_s;
            tx_start_r <= (state_next_s == ISSUE);
            ovf_r      <= ovf_next_s;
            if (pop_s) begin
                tx_data_r <= fifo_head_s;
            end
        end
    end

    assign bus.TX_START = tx_start_r;
    assign bus.TX_DATA  = tx_data_r;
    assign bus.COUNT    = fifo_count_s;
    assign bus.FULL     = fifo_full_s;
    assign bus.EMPTY    = fifo_empty_s;
    assign bus.OVERFLOW = ovf_r;
    assign bus.BUSY     = (state_r != IDLE) || !fifo_empty_s;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a byte-queue reference model with a
// simple in-flight/acknowledged view of the UART handshake, a small latency
// vector table, directed corner sequences and a randomized run.
module tb_uart_tx_fifo;
    localparam int DEPTH       = 16;
    localparam int DW          = 8;
    localparam int ACK_TIMEOUT = 64;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;

    uart_tx_fifo_if #(.DEPTH(DEPTH), .DW(DW)) bus ();

    uart_tx_fifo #(
        .DEPTH       (DEPTH),
        .DW          (DW),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // reference model
    logic [7:0] q[$];
    logic       m_busy;
    int         m_age;
    logic       m_acked;
    logic       m_ovf;
    logic [7:0] m_data;
    logic       m_start;

    logic [7:0] out_log[$];
    int         start_times[$];
    int         start_counts[$];

    // UART behaviour: READY drops one cycle after START for u_len cycles
    int u_low, u_delay, u_len;

    typedef struct {
        logic       wr;
        logic [7:0] d;
        logic       rdy;
        logic       e_start;
        logic [7:0] e_data;
        int         e_count;
        logic       e_empty;
    } vec_t;
    vec_t tbl[5];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_busy  = 1'b0;
        m_age   = 0;
        m_acked = 1'b0;
        m_ovf   = 1'b0;
        m_data  = 8'h00;
        m_start = 1'b0;
    endtask

    task automatic check_all(input string nm);
        chk({nm, ".start"}, int'(bus.TX_START), int'(m_start));
        chk({nm, ".data"},  int'(bus.TX_DATA),  int'(m_data));
        chk({nm, ".count"}, int'(bus.COUNT),    q.size());
        chk({nm, ".full"},  int'(bus.FULL),     int'(q.size() == DEPTH));
        chk({nm, ".empty"}, int'(bus.EMPTY),    int'(q.size() == 0));
        chk({nm, ".ovf"},   int'(bus.OVERFLOW), int'(m_ovf));
        chk({nm, ".busy"},  int'(bus.BUSY),     int'(m_busy || (q.size() > 0)));
    endtask

    // Apply one cycle of inputs, advance the model across the edge, compare.
    task automatic cycle(input string nm, input logic wr, input logic [7:0] d,
                         input logic clr, input logic rdy);
        logic pop;
        logic was_full;
        bus.WR_EN    = wr;
        bus.WR_DATA  = d;
        bus.CLR_OVF  = clr;
        bus.TX_READY = rdy;
        was_full = (q.size() == DEPTH);
        pop      = !m_busy && (q.size() > 0) && rdy;
        m_start  = pop;
        if (m_busy) begin
            // first edge after the pop is the START cycle; READY is ignored there
            m_age++;
            if (m_age >= 2) begin
                if (m_acked) begin
                    if (rdy) m_busy = 1'b0;
                end else if (!rdy) begin
                    m_acked = 1'b1;
                end else if (m_age == ACK_TIMEOUT + 1) begin
                    m_busy = 1'b0;
                end
            end
        end
        if (pop) begin
            m_data  = q.pop_front();
            m_busy  = 1'b1;
            m_age   = 0;
            m_acked = 1'b0;
        end
        if (wr && (!was_full || pop)) q.push_back(d);
        if (wr && was_full && !pop) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        @(posedge CLK);
        #1;
        cyc++;
        if (bus.TX_START) begin
            out_log.push_back(bus.TX_DATA);
            start_times.push_back(cyc);
            start_counts.push_back(int'(bus.COUNT));
        end
        check_all(nm);
    endtask

    task automatic uart_cycle(input string nm, input logic wr, input logic [7:0] d,
                              input logic clr);
        logic r;
        r = (u_low == 0);
        if (u_low > 0) begin
            u_low--;
        end else if (u_delay > 0) begin
            u_delay--;
            if (u_delay == 0) u_low = u_len;
        end
        cycle(nm, wr, d, clr, r);
        if (bus.TX_START && u_len > 0) u_delay = 1;
    endtask

    task automatic drain(input string nm, input int budget);
        int c;
        c = 0;
        while (c < budget && (q.size() > 0 || m_busy || u_low > 0 || u_delay > 0)) begin
            uart_cycle(nm, 1'b0, 8'h00, 1'b0);
            c++;
        end
        chk({nm, ".in_budget"}, int'(c < budget), 1);
    endtask

    initial begin
        bus.WR_EN    = 1'b0;
        bus.WR_DATA  = 8'h00;
        bus.CLR_OVF  = 1'b0;
        bus.TX_READY = 1'b0;
        u_low = 0; u_delay = 0; u_len = 0;
        model_reset();

        tbl[0] = '{1'b1, 8'h41, 1'b1, 1'b0, 8'h00, 1, 1'b0};
        tbl[1] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h41, 0, 1'b1};
        tbl[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h41, 0, 1'b1};
        tbl[3] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h41, 0, 1'b1};
        tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h41, 0, 1'b1};

        // reset state
        repeat (2) @(posedge CLK);
        #1;
        check_all("reset");
        RST_N = 1'b1;

        // write-to-start latency
        for (int i = 0; i < 5; i++) begin
            cycle($sformatf("lat%0d", i), tbl[i].wr, tbl[i].d, 1'b0, tbl[i].rdy);
            chk($sformatf("tbl%0d.start", i), int'(bus.TX_START), int'(tbl[i].e_start));
            chk($sformatf("tbl%0d.data", i),  int'(bus.TX_DATA),  int'(tbl[i].e_data));
            chk($sformatf("tbl%0d.count", i), int'(bus.COUNT),    tbl[i].e_count);
            chk($sformatf("tbl%0d.empty", i), int'(bus.EMPTY),    int'(tbl[i].e_empty));
        end

        // fill with READY low, overflow, clear
        for (int i = 0; i < 16; i++) cycle("fill", 1'b1, 8'(i), 1'b0, 1'b0);
        chk("fill.full", int'(bus.FULL), 1);
        chk("fill.count", int'(bus.COUNT), 16);
        cycle("ovf_wr", 1'b1, 8'hFF, 1'b0, 1'b0);
        chk("ovf.flag", int'(bus.OVERFLOW), 1);
        chk("ovf.count", int'(bus.COUNT), 16);
        cycle("ovf_clr", 1'b0, 8'h00, 1'b1, 1'b0);
        chk("clr.flag", int'(bus.OVERFLOW), 0);

        // write while full in the pop cycle, then drain with a handshaking UART
        out_log.delete();
        u_low = 0; u_delay = 0; u_len = 10;
        cycle("aa_pop", 1'b1, 8'hAA, 1'b0, 1'b1);
        if (bus.TX_START) u_delay = 1;
        chk("aa.ovf", int'(bus.OVERFLOW), 0);
        chk("aa.count", int'(bus.COUNT), 16);
        chk("aa.full", int'(bus.FULL), 1);
        drain("drain", 2000);
        chk("drain.n_start", out_log.size(), 17);
        for (int i = 0; i < out_log.size(); i++)
            chk($sformatf("drain.byte%0d", i), int'(out_log[i]), (i < 16) ? i : 8'hAA);

        // UART that never drops READY: timeout paces the bytes
        for (int i = 0; i < 3; i++) cycle("tmo_fill", 1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
        start_times.delete();
        start_counts.delete();
        u_low = 0; u_delay = 0; u_len = 0;
        drain("tmo", 1000);
        chk("tmo.n_start", start_times.size(), 3);
        for (int i = 0; i < start_counts.size(); i++)
            chk($sformatf("tmo.count%0d", i), start_counts[i], 2 - i);
        for (int i = 1; i < start_times.size(); i++)
            chk($sformatf("tmo.gap%0d", i), start_times[i] - start_times[i-1], ACK_TIMEOUT + 2);

        // reset while waiting for READY to rise, 5 bytes still queued
        for (int i = 0; i < 6; i++) cycle("rst_fill", 1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
        cycle("rst_pop", 1'b0, 8'h00, 1'b0, 1'b1);
        cycle("rst_issue", 1'b0, 8'h00, 1'b0, 1'b0);
        cycle("rst_ack", 1'b0, 8'h00, 1'b0, 1'b0);
        chk("rst.pre_count", int'(bus.COUNT), 5);
        RST_N = 1'b0;
        #1;
        model_reset();
        chk("rst.count", int'(bus.COUNT), 0);
        chk("rst.empty", int'(bus.EMPTY), 1);
        chk("rst.busy", int'(bus.BUSY), 0);
        @(posedge CLK);
        #1;
        check_all("rst_hold");
        RST_N = 1'b1;
        begin
            int n0;
            n0 = start_times.size();
            for (int i = 0; i < 12; i++) cycle("post_rst", 1'b0, 8'h00, 1'b0, 1'b1);
            chk("post_rst.no_start", start_times.size() - n0, 0);
        end
        cycle("post_wr", 1'b1, 8'h5A, 1'b0, 1'b1);
        cycle("post_pop", 1'b0, 8'h00, 1'b0, 1'b1);
        chk("post.data", int'(bus.TX_DATA), 8'h5A);
        cycle("post_end", 1'b0, 8'h00, 1'b0, 1'b0);
        cycle("post_end", 1'b0, 8'h00, 1'b0, 1'b1);

        // randomized traffic with a UART of varying speed
        u_low = 0; u_delay = 0; u_len = 0;
        for (int i = 0; i < 2000; i++) begin
            logic wr, clr;
            if (u_low == 0 && u_delay == 0)
                u_len = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 6);
            wr  = ($urandom_range(0, 2) == 0);
            clr = ($urandom_range(0, 15) == 0);
            uart_cycle("rand", wr, 8'($urandom), clr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte buffer between the MCU IOBUS write decode (UART data port) and the UART transmitter.
- Accepts bytes as single-cycle write strobes from the IOBUS side. The CPU can burst up to DEPTH bytes without polling UART readiness.
- A drain FSM pops one byte at a time and issues it to the UART using its start/ready handshake.
- Exposes fill status and a sticky overflow flag; the wrapper maps these onto an IOBUS read address.

Parameters:
- DEPTH, 16, number of byte entries; power of two, minimum 2.
- DW, 8, data width per entry.
- ACK_TIMEOUT, 64, cycles to wait in WAIT_ACK for READY to drop before the byte is treated as consumed.

Ports:
- CLK  in  1  single system clock (the MCU clock).
- RST_N  in  1  asynchronous active-low reset.
- WR_EN  in  1  one-cycle write strobe from the IOBUS decode.
- WR_DATA  in  DW  byte to enqueue.
- CLR_OVF  in  1  one-cycle strobe that clears OVERFLOW.
- TX_READY  in  1  from the UART: 1 means idle and able to accept a byte.
- TX_START  out  1  one-cycle pulse to the UART.
- TX_DATA  out  DW  byte presented to the UART; stable from the TX_START cycle until the next TX_START.
- COUNT  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- FULL  out  1  COUNT==DEPTH.
- EMPTY  out  1  COUNT==0.
- OVERFLOW  out  1  sticky: a write was attempted while full.
- BUSY  out  1  FSM not in IDLE, or EMPTY==0.

Behaviour:
- Reset (RST_N=0, asynchronous):
  - Pointers = 0, COUNT = 0, EMPTY = 1, FULL = 0, OVERFLOW = 0.
  - TX_START = 0, TX_DATA = 0, BUSY = 0, FSM = IDLE, timeout counter = 0.
  - Memory contents are undefined and need no reset.
  - Reset mid-transfer discards all queued bytes and aborts the handshake. No TX_START is issued while RST_N=0 or on the first cycle after release.
- Write:
  - WR_EN && !FULL: mem[wr_ptr] <= WR_DATA; wr_ptr increments mod DEPTH.
  - WR_EN && FULL: data is dropped, pointers are unchanged, OVERFLOW <= 1.
  - CLR_OVF clears OVERFLOW. If CLR_OVF and an overflowing write occur in the same cycle, set wins (OVERFLOW = 1).
- Pop:
  - Occurs only in the FSM IDLE->ISSUE transition; rd_ptr increments mod DEPTH.
  - Pointers are DEPTH-wrapped. COUNT is held in a separate counter and is never derived from pointer subtraction.
- Simultaneous write and pop: both take effect and COUNT is unchanged. This also applies when FULL: a pop frees an entry in the same cycle, so the write is accepted and OVERFLOW is not set.
- FSM states, all transitions registered:
  - IDLE: if !EMPTY && TX_READY, then TX_DATA <= mem[rd_ptr], pop, go to ISSUE. Otherwise stay.
  - ISSUE: TX_START=1 for exactly this one cycle; clear the timeout counter; go to WAIT_ACK.
  - WAIT_ACK: if TX_READY==0, go to WAIT_DONE. Otherwise increment the counter; when it reaches ACK_TIMEOUT-1, go to IDLE (byte considered sent).
  - WAIT_DONE: if TX_READY==1, go to IDLE.
- Latency: a byte written into an empty FIFO with TX_READY=1 produces TX_START two cycles after the WR_EN cycle (write at edge N, IDLE pop at edge N+1, TX_START high during cycle N+2).
- The write path accepts a write into an empty FIFO in the same cycle the FSM is in any state. There is no read-through bypass.
- Minimum spacing between TX_START pulses is 4 cycles (IDLE, ISSUE, WAIT_ACK, WAIT_DONE).
- COUNT, FULL, EMPTY and OVERFLOW are registered outputs, updated on the edge following the event.

Decomposition:
- Shared package otter_io_pkg:
  - the UART data/status IOBUS address constants;
  - typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE} uart_tx_state_t.
- One natural sub-module: sync_fifo. It is a generic DEPTH×DW single-clock FIFO with push/pop/count/full/empty and async active-low reset.
- uart_tx_fifo instantiates sync_fifo and adds the overflow flag and drain FSM.

Test Plan:
- Reset, then WR_EN with WR_DATA=8'h41, TX_READY=1 -> TX_START high exactly 2 cycles later with TX_DATA=8'h41; then COUNT=0, EMPTY=1.
- TX_READY held 0; write 16 bytes 8'h00..8'h0F -> FULL=1, COUNT=16. A 17th write of 8'hFF -> OVERFLOW=1, COUNT=16. CLR_OVF -> OVERFLOW=0.
- From the full state, release TX_READY; a UART model drops READY 1 cycle after START and raises it 10 cycles later -> bytes emerge in order 8'h00..8'h0F, with no 8'hFF, and exactly 16 TX_START pulses.
- FULL and FSM in IDLE with TX_READY=1, write 8'hAA in the same cycle as the pop -> write accepted, OVERFLOW stays 0, COUNT stays 16, and 8'hAA is the last byte out.
- UART model never drops READY -> after ACK_TIMEOUT=64 cycles in WAIT_ACK the FSM returns to IDLE and the next byte is issued; COUNT decrements by 1 per byte.
- Assert RST_N=0 during WAIT_DONE with 5 bytes queued -> COUNT=0, EMPTY=1, BUSY=0 immediately; no TX_START after release until new writes occur.
